// File: rtl/i2c_entity.sv
// Single-master I2C register engine for one ToF sensor lane.
// One transaction per accepted start: 7-bit slave address, 16-bit register
// index (MSB byte first), then 1 or 2 data bytes written or read.
// SCL comes from a quarter-period divider. Both lines are open-drain: the
// *_t outputs release the line when 1 and pull it low when 0.
module i2c_entity #(
  parameter int QUARTER_CYCLES = 63
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        is_read,
  input  logic        nb_of_bytes,
  input  logic [6:0]  slave_adress,
  input  logic [15:0] register_address,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        ready,
  output logic        error_out,
  input  logic        SCL_in,
  input  logic        SDA_in,
  output logic        SCL_out,
  output logic        SDA_out,
  output logic        SCL_t,
  output logic        SDA_t
);

  localparam int            QW    = (QUARTER_CYCLES > 2) ? $clog2(QUARTER_CYCLES) : 1;
  localparam logic [QW-1:0] QLAST = QW'(QUARTER_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SEND_BYTE,
    S_SLAVE_ACK,
    S_RSTART,
    S_RECV_BYTE,
    S_MASTER_ACK,
    S_STOP
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [QW-1:0] r_qcnt;    // cycle within the current quarter
  logic [1:0]    r_q;       // quarter within the current bit
  logic [2:0]    r_bit;     // bit index within a byte
  logic [2:0]    r_byte;    // 0 addr, 1 regH, 2 regL, 3 D0 / read addr, 4..5 data
  logic [7:0]    r_sh;      // transmit / receive shift register
  logic          r_nack;    // SDA level seen at the slave ACK sample
  logic          r_err;
  logic [7:0]    r_data_out;
  logic [6:0]    r_addr;
  logic [15:0]   r_reg;
  logic          r_rd;
  logic          r_nb;

  logic          w_scl_t;
  logic          w_sda_t;
  logic          w_hold;
  logic          w_qend;
  logic          w_bend;
  logic          w_sample;
  logic          w_last;
  logic [7:0]    w_load_byte;

  // A slave stretching the clock keeps SCL_in low after we released it.
  assign w_hold   = w_scl_t & ~SCL_in;
  assign w_qend   = (r_state != S_IDLE) && (r_qcnt == QLAST) && !w_hold;
  assign w_bend   = w_qend && (r_q == 2'd3);
  assign w_sample = w_qend && (r_q == 2'd2);

  // The final read byte is answered with NACK.
  assign w_last = ((r_byte == 3'd4) && !r_nb) || (r_byte == 3'd5);

  // Byte to transmit after the ACK of byte r_byte; data_in is taken live.
  always_comb begin
    w_load_byte = data_in;
    case (r_byte)
      3'd0:    w_load_byte = r_reg[15:8];
      3'd1:    w_load_byte = r_reg[7:0];
      default: w_load_byte = data_in;
    endcase
  end

  // Quarter/cycle divider; frozen while the bus is stretched, idle when not busy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_qcnt <= '0;
      r_q    <= 2'd0;
    end else if (r_state == S_IDLE) begin
      r_qcnt <= '0;
      r_q    <= 2'd0;
    end else if (w_qend) begin
      r_qcnt <= '0;
      r_q    <= r_q + 2'd1;
    end else if (!w_hold) begin
      r_qcnt <= r_qcnt + QW'(1);
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state: every non-idle state advances on bit boundaries only.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:       if (start) w_state_nxt = S_START;
      S_START:      if (w_bend) w_state_nxt = S_SEND_BYTE;
      S_SEND_BYTE:  if (w_bend && (r_bit == 3'd7)) w_state_nxt = S_SLAVE_ACK;
      S_SLAVE_ACK: begin
        if (w_bend) begin
          if (r_nack) begin
            w_state_nxt = S_STOP;
          end else if (r_rd) begin
            case (r_byte)
              3'd2:    w_state_nxt = S_RSTART;
              3'd3:    w_state_nxt = S_RECV_BYTE;
              default: w_state_nxt = S_SEND_BYTE;
            endcase
          end else if ((r_byte <= 3'd2) || ((r_byte == 3'd3) && r_nb)) begin
            w_state_nxt = S_SEND_BYTE;
          end else begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_RSTART:     if (w_bend) w_state_nxt = S_START;
      S_RECV_BYTE:  if (w_bend && (r_bit == 3'd7)) w_state_nxt = S_MASTER_ACK;
      S_MASTER_ACK: if (w_bend) w_state_nxt = w_last ? S_STOP : S_RECV_BYTE;
      S_STOP:       if (w_bend) w_state_nxt = S_IDLE;
      default:      w_state_nxt = S_IDLE;
    endcase
  end

  // Datapath: request latch, shift register, byte/bit counters, status.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_bit      <= 3'd0;
      r_byte     <= 3'd0;
      r_sh       <= 8'hFF;
      r_nack     <= 1'b0;
      r_err      <= 1'b0;
      r_data_out <= 8'h00;
      r_addr     <= 7'd0;
      r_reg      <= 16'd0;
      r_rd       <= 1'b0;
      r_nb       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_addr <= slave_adress;
            r_reg  <= register_address;
            r_rd   <= is_read;
            r_nb   <= nb_of_bytes;
            r_err  <= 1'b0;
            r_byte <= 3'd0;
            r_bit  <= 3'd0;
            r_nack <= 1'b0;
          end
        end
        S_START: begin
          // First START carries the write address, the repeated one the read.
          if (w_bend) begin
            r_sh  <= {r_addr, (r_byte != 3'd0)};
            r_bit <= 3'd0;
          end
        end
        S_SEND_BYTE: begin
          if (w_bend) begin
            r_sh  <= {r_sh[6:0], 1'b1};
            r_bit <= r_bit + 3'd1;
          end
        end
        S_SLAVE_ACK: begin
          if (w_sample) r_nack <= SDA_in;
          if (w_bend) begin
            r_byte <= r_byte + 3'd1;
            r_sh   <= w_load_byte;
            r_bit  <= 3'd0;
            if (r_nack) r_err <= 1'b1;
          end
        end
        S_RECV_BYTE: begin
          if (w_sample) begin
            r_sh <= {r_sh[6:0], SDA_in};
            if (r_bit == 3'd7) r_data_out <= {r_sh[6:0], SDA_in};
          end
          if (w_bend) r_bit <= r_bit + 3'd1;
        end
        S_MASTER_ACK: begin
          if (w_bend) begin
            r_byte <= r_byte + 3'd1;
            r_bit  <= 3'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Line drive per state and quarter; SCL is low in Q0/Q1, released in Q2/Q3.
  always_comb begin
    w_scl_t = 1'b1;
    w_sda_t = 1'b1;
    case (r_state)
      S_START: begin
        w_scl_t = (r_q != 2'd3);
        w_sda_t = ~r_q[1];
      end
      S_SEND_BYTE: begin
        w_scl_t = r_q[1];
        w_sda_t = r_sh[7];
      end
      S_SLAVE_ACK, S_RSTART, S_RECV_BYTE: begin
        w_scl_t = r_q[1];
      end
      S_MASTER_ACK: begin
        w_scl_t = r_q[1];
        w_sda_t = w_last;
      end
      S_STOP: begin
        w_scl_t = r_q[1];
        w_sda_t = (r_q == 2'd3);
      end
      default: ;
    endcase
  end

  assign SCL_t     = w_scl_t;
  assign SDA_t     = w_sda_t;
  assign SCL_out   = 1'b0;
  assign SDA_out   = 1'b0;
  assign ready     = (r_state == S_IDLE);
  assign error_out = r_err;
  assign data_out  = r_data_out;

endmodule

// File: tb/tb_i2c_entity.sv
// Directed bench for i2c_entity with a behavioural I2C slave/bus monitor.
module tb_i2c_entity;
  localparam int QC = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        is_read;
  logic        nb_of_bytes;
  logic [6:0]  slave_adress;
  logic [15:0] register_address;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        ready;
  logic        error_out;
  logic        SCL_out, SDA_out, SCL_t, SDA_t;
  logic        bus_scl, bus_sda;

  // Slave-side line pulls (owned by the monitor process).
  logic        stretch = 1'b0;
  logic        slave_sda_low = 1'b0;

  assign bus_scl = SCL_t & ~stretch;
  assign bus_sda = SDA_t & ~slave_sda_low;

  always #5 clk = ~clk;

  i2c_entity #(.QUARTER_CYCLES(QC)) dut (
    .clock(clk), .reset(rst_n), .start(start), .is_read(is_read),
    .nb_of_bytes(nb_of_bytes), .slave_adress(slave_adress),
    .register_address(register_address), .data_in(data_in),
    .data_out(data_out), .ready(ready), .error_out(error_out),
    .SCL_in(bus_scl), .SDA_in(bus_sda), .SCL_out(SCL_out), .SDA_out(SDA_out),
    .SCL_t(SCL_t), .SDA_t(SDA_t)
  );

  int checks = 0;
  int errors = 0;

  // Controls written by the stimulus process only.
  int clr_epoch   = 0;
  bit nack_mode   = 1'b0;
  bit stretch_req = 1'b0;

  // Monitor state.
  logic [7:0] mon_bytes [16];
  logic       mon_acks  [16];
  int mon_nb = 0, mon_na = 0, n_start = 0, n_stop = 0, busy = 0;
  int bitcnt = 0, rd_idx = 0, stretch_cnt = 0, seen_epoch = 0;
  bit first = 0, rd_mode = 0, tx = 0, last_ack = 1, stretch_used = 0;
  bit prev_scl = 1, prev_sda = 1;
  logic [7:0] sh = 8'h00, txb = 8'h00;

  // Bus monitor and slave: decodes START/STOP/bits, ACKs, returns read data, stretches.
  always @(negedge clk) begin : mon
    bit s, d;
    s = bus_scl;
    d = bus_sda;
    if (seen_epoch != clr_epoch) begin
      seen_epoch = clr_epoch;
      mon_nb = 0; mon_na = 0; n_start = 0; n_stop = 0; busy = 0;
      bitcnt = 0; first = 0; rd_mode = 0; tx = 0; rd_idx = 0; last_ack = 1;
      stretch = 1'b0; stretch_cnt = 0; stretch_used = 0; slave_sda_low = 1'b0;
    end
    if (stretch_cnt > 0) begin
      stretch_cnt--;
      if (stretch_cnt == 0) stretch = 1'b0;
    end
    if (!ready) busy++;
    if (prev_scl && s && prev_sda && !d) begin
      n_start++; bitcnt = 0; first = 1; tx = 0;
    end else if (prev_scl && s && !prev_sda && d) begin
      n_stop++; bitcnt = 0; tx = 0; slave_sda_low = 1'b0;
    end else if (!prev_scl && s) begin
      if (bitcnt < 8) begin
        sh = {sh[6:0], d};
        bitcnt++;
        if (bitcnt == 8) begin
          if (mon_nb < 16) mon_bytes[mon_nb] = sh;
          mon_nb++;
          if (first) rd_mode = sh[0];
        end
      end else if (bitcnt == 8) begin
        if (mon_na < 16) mon_acks[mon_na] = d;
        mon_na++;
        last_ack = d;
        bitcnt = 9;
      end
    end else if (prev_scl && !s) begin
      if (bitcnt == 8) begin
        slave_sda_low = tx ? 1'b0 : !nack_mode;
        if (stretch_req && !stretch_used) begin
          stretch = 1'b1; stretch_cnt = 2*QC + 10; stretch_used = 1;
        end
      end else if (bitcnt == 9) begin
        bitcnt = 0;
        if (first && rd_mode && !last_ack) tx = 1;
        else if (tx && last_ack) tx = 0;
        first = 0;
        if (tx) begin
          txb = (rd_idx == 0) ? 8'h3C : 8'h7E;
          rd_idx++;
          slave_sda_low = !txb[7];
        end else begin
          slave_sda_low = 1'b0;
        end
      end else if (tx && bitcnt >= 1 && bitcnt <= 7) begin
        slave_sda_low = !txb[7-bitcnt];
      end
    end
    prev_scl = s;
    prev_sda = d;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input int n, input logic [63:0] eb,
                         input logic [7:0] ea, input int ns, input int np);
    chk({tag, " nbytes"}, mon_nb, n);
    chk({tag, " nacks"}, mon_na, n);
    for (int i = 0; i < n && i < 8; i++) begin
      chk($sformatf("%s byte%0d", tag, i), 32'(mon_bytes[i]), 32'(eb[8*(n-1-i) +: 8]));
      chk($sformatf("%s ack%0d", tag, i), 32'(mon_acks[i]), 32'(ea[n-1-i]));
    end
    chk({tag, " starts"}, n_start, ns);
    chk({tag, " stops"}, n_stop, np);
  endtask

  task automatic mon_clear();
    clr_epoch++;
    repeat (2) @(negedge clk);
  endtask

  task automatic run_txn(input logic rd, input logic nb, input logic [6:0] a,
                         input logic [15:0] rg, input logic [7:0] d);
    @(negedge clk);
    is_read = rd; nb_of_bytes = nb; slave_adress = a; register_address = rg;
    data_in = d; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ready && k < 20000);
    chk({tag, " done"}, 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; is_read = 1'b0; nb_of_bytes = 1'b0;
    slave_adress = 7'd0; register_address = 16'd0; data_in = 8'd0;
    repeat (3) @(negedge clk);
    chk("rst ready", 32'(ready), 32'd1);
    chk("rst error", 32'(error_out), 32'd0);
    chk("rst data", 32'(data_out), 32'd0);
    chk("rst scl_t", 32'(SCL_t), 32'd1);
    chk("rst sda_t", 32'(SDA_t), 32'd1);
    chk("rst pads", {30'd0, SCL_out, SDA_out}, 32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 1: single-byte write, slave ACKs everything; 38 bits of 16 cycles.
    mon_clear();
    run_txn(1'b0, 1'b0, 7'h29, 16'h0123, 8'hA5);
    chk("wr ready_low", 32'(ready), 32'd0);
    wait_ready("wr");
    chk_bus("wr", 4, 64'h52_01_23_A5, 8'b0000, 1, 1);
    chk("wr busy", busy, 608);
    chk("wr error", 32'(error_out), 32'd0);

    // 2: two-byte read with repeated START; master ACK then NACK.
    mon_clear();
    run_txn(1'b1, 1'b1, 7'h29, 16'h0123, 8'h00);
    wait_ready("rd");
    chk_bus("rd", 6, 64'h52_01_23_53_3C_7E, 8'b000001, 2, 1);
    chk("rd data_out", 32'(data_out), 32'h7E);
    chk("rd error", 32'(error_out), 32'd0);

    // 3: address NACK aborts straight into STOP; 11 bits.
    nack_mode = 1'b1;
    mon_clear();
    run_txn(1'b0, 1'b0, 7'h29, 16'h0123, 8'hA5);
    wait_ready("nack");
    chk_bus("nack", 1, 64'h52, 8'b1, 1, 1);
    chk("nack error", 32'(error_out), 32'd1);
    chk("nack busy", busy, 176);
    nack_mode = 1'b0;

    // 4: two-byte write; error clears on accept, start while busy ignored,
    //    data_in re-sampled for the second data byte. 47 bits.
    mon_clear();
    run_txn(1'b0, 1'b1, 7'h29, 16'h4455, 8'h5A);
    chk("wr2 error_clr", 32'(error_out), 32'd0);
    repeat (48) @(negedge clk);
    start = 1'b1; is_read = 1'b1; slave_adress = 7'h11;
    @(negedge clk);
    start = 1'b0;
    repeat (450) @(negedge clk);
    data_in = 8'hC3;
    wait_ready("wr2");
    chk_bus("wr2", 5, 64'h52_44_55_5A_C3, 8'b00000, 1, 1);
    chk("wr2 busy", busy, 752);
    repeat (200) @(negedge clk);
    chk("wr2 idle_ready", 32'(ready), 32'd1);
    chk("wr2 idle_starts", n_start, 1);
    chk("wr2 data_out_kept", 32'(data_out), 32'h7E);

    // 5: reset in the middle of the address byte.
    mon_clear();
    run_txn(1'b0, 1'b0, 7'h29, 16'h0123, 8'hA5);
    repeat (100) @(negedge clk);
    chk("mid busy", 32'(ready), 32'd0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid scl_t", 32'(SCL_t), 32'd1);
    chk("mid sda_t", 32'(SDA_t), 32'd1);
    chk("mid ready", 32'(ready), 32'd1);
    chk("mid error", 32'(error_out), 32'd0);
    chk("mid data", 32'(data_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // 6: slave stretches SCL for 10 cycles in the address ACK bit.
    stretch_req = 1'b1;
    mon_clear();
    run_txn(1'b0, 1'b0, 7'h29, 16'h0123, 8'hA5);
    wait_ready("str");
    chk_bus("str", 4, 64'h52_01_23_A5, 8'b0000, 1, 1);
    chk("str busy", busy, 618);
    chk("str error", 32'(error_out), 32'd0);
    stretch_req = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
